// File: rtl/clk_switch_ctrl_if.sv
// Request/status handshake between the clock control registers and clk_switch_ctrl.
interface clk_switch_ctrl_if;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic busy;
    logic done;
    logic err;

    modport master (output req_valid, req_sel, input req_ready, busy, done, err);
    modport slave  (input req_valid, req_sel, output req_ready, busy, done, err);
endinterface

// File: rtl/clk_switch_ctrl.sv
// Sequencer for the 2:1 glitch-free clock mux select, running on the always-on clk0.
// Optional continuous clk1 failover monitoring is compiled in with CLK_FAILOVER_EN.
module clk_switch_ctrl #(
    parameter int CHECK_WIN   = 64,
    parameter int MIN_TOGGLES = 4,
    parameter int SETTLE_CYC  = 8
) (
    input  logic               clk0,
    input  logic               rst_n,
    clk_switch_ctrl_if.slave   req,
    input  logic               clk1_tog,
    output logic               sel,
    output logic               cur_src,
    output logic               clk_fail
);
    localparam int WW = $clog2(CHECK_WIN) + 1;
    localparam int TW = $clog2(MIN_TOGGLES) + 1;
    localparam int SW = $clog2(SETTLE_CYC) + 1;
    localparam logic [WW-1:0] WIN_LAST    = WW'(CHECK_WIN - 1);
    localparam logic [TW-1:0] TOG_MIN     = TW'(MIN_TOGGLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SETTLE, DONE, ERR} state_t;

    state_t        state;
    logic          target;
    logic [1:0]    tog_sync;
    logic          tog_prev;
    logic          tog_evt;
    logic [WW-1:0] win_cnt;
    logic [TW-1:0] tog_cnt;
    logic [TW-1:0] tog_cnt_inc;
    logic [SW-1:0] settle_cnt;
    logic          busy_reg;
    logic          ready_reg;
    logic          done_reg;
    logic          err_reg;

    assign req.busy      = busy_reg;
    assign req.req_ready = ready_reg;
    assign req.done      = done_reg;
    assign req.err       = err_reg;

    // Each change of the synchronised clk1 toggle counts as one liveness event.
    assign tog_evt     = tog_sync[1] ^ tog_prev;
    assign tog_cnt_inc = (tog_evt && (tog_cnt != TOG_MIN)) ? tog_cnt + 1'b1 : tog_cnt;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            tog_sync <= 2'b00;
            tog_prev <= 1'b0;
        end else begin
            tog_sync <= {tog_sync[0], clk1_tog};
            tog_prev <= tog_sync[1];
        end
    end

`ifdef CLK_FAILOVER_EN
    logic [WW-1:0] mon_cnt;
    logic          clk_fail_reg;
    assign clk_fail = clk_fail_reg;
`else
    assign clk_fail = 1'b0;
`endif

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= 1'b0;
            sel        <= 1'b0;
            cur_src    <= 1'b0;
            win_cnt    <= '0;
            tog_cnt    <= '0;
            settle_cnt <= '0;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
`ifdef CLK_FAILOVER_EN
            mon_cnt      <= '0;
            clk_fail_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
`ifdef CLK_FAILOVER_EN
            mon_cnt  <= '0;
`endif
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        target    <= req.req_sel;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
`ifdef CLK_FAILOVER_EN
                        clk_fail_reg <= 1'b0;
`endif
                        if (req.req_sel == cur_src) begin
                            state    <= DONE;
                            done_reg <= 1'b1;
                        end else if (!req.req_sel) begin
                            state      <= SETTLE;
                            sel        <= 1'b0;
                            settle_cnt <= '0;
                        end else begin
                            state   <= CHECK;
                            win_cnt <= '0;
                            tog_cnt <= '0;
                        end
                    end
`ifdef CLK_FAILOVER_EN
                    // A dead clk1 cannot hand the mux back, so force clk0 and flag it.
                    else if (cur_src) begin
                        if (tog_evt) begin
                            mon_cnt <= '0;
                        end else if (mon_cnt == WIN_LAST) begin
                            sel          <= 1'b0;
                            cur_src      <= 1'b0;
                            clk_fail_reg <= 1'b1;
                            err_reg      <= 1'b1;
                        end else begin
                            mon_cnt <= mon_cnt + 1'b1;
                        end
                    end
`endif
                end
                CHECK: begin
                    tog_cnt <= tog_cnt_inc;
                    if (win_cnt == WIN_LAST) begin
                        if (tog_cnt_inc >= TOG_MIN) begin
                            state      <= SETTLE;
                            sel        <= 1'b1;
                            settle_cnt <= '0;
                        end else begin
                            state   <= ERR;
                            err_reg <= 1'b1;
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state    <= DONE;
                        done_reg <= 1'b1;
                        cur_src  <= target;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    state     <= IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end
endmodule
